// File: rtl/riscv_pkg.sv
// Shared fetch-path types: word width, fetch FSM states and the buffered entry format.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries; flush overrides push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output fetch_entry_t head
);
  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding memory fetch FSM feeding a prefetch FIFO.
// Optional stall counter output o_stall_cnt when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            i_clk,
  input  logic            rst,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     o_stall_cnt
`endif
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [AW:0]     count;
  logic [AW+1:0]   count_after_push;
  fetch_entry_t    din, head;
  logic            push, pop;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^i_redirect_pc[1:0];

  assign o_instr_valid = (count != '0);
  assign pop  = o_instr_valid && i_instr_ready && !i_redirect;
  assign push = (state == WAIT) && i_mem_rvalid && !i_redirect;
  assign o_mem_addr = fetch_pc;
  assign o_instr    = o_instr_valid ? head.instr : '0;
  assign o_instr_pc = o_instr_valid ? head.pc    : '0;

  // fetch_pc already advanced on gnt, so the in-flight word lives one word back.
  always_comb begin
    din       = '0;
    din.pc    = fetch_pc - XLEN'(4);
    din.instr = i_mem_rdata;
  end

  assign count_after_push = {1'b0, count} + (AW+2)'(1) - (AW+2)'(pop);

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk (i_clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      o_mem_req <= 1'b0;
    end else if (i_redirect) begin
      fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      case (state)
        REQ: begin
          state     <= i_mem_gnt ? DRAIN : REQ;
          o_mem_req <= !i_mem_gnt;
        end
        WAIT, DRAIN: begin
          state     <= i_mem_rvalid ? REQ : DRAIN;
          o_mem_req <= i_mem_rvalid;
        end
        default: begin
          state     <= REQ;
          o_mem_req <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        IDLE: if ({1'b0, count} < DEPTH_W) begin
          state     <= REQ;
          o_mem_req <= 1'b1;
        end
        REQ: if (i_mem_gnt) begin
          fetch_pc  <= fetch_pc + XLEN'(4);
          state     <= WAIT;
          o_mem_req <= 1'b0;
        end
        WAIT: if (i_mem_rvalid) begin
          state     <= (count_after_push < DEPTH_W) ? REQ : IDLE;
          o_mem_req <= (count_after_push < DEPTH_W);
        end
        DRAIN: if (i_mem_rvalid) begin
          state     <= REQ;
          o_mem_req <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)
      o_stall_cnt <= '0;
    else if (i_instr_ready && !o_instr_valid && (o_stall_cnt != '1))
      o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a latency-varying memory model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        i_clk = 1'b0, rst = 1'b1;
  logic        mem_req, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0;
  logic        instr_valid, ready = 1'b0;
  logic [31:0] mem_addr, rdata = '0, redirect_pc = '0, instr, instr_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0, checks = 0, n_pop = 0;
  int gnt_pct = 100, lat_min = 0, lat_max = 0;
  logic [31:0]  acc_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  next_exp;

  always #5 i_clk = ~i_clk;

  instr_fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .i_clk         (i_clk),
    .rst           (rst),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_gnt     (gnt),
    .i_mem_rvalid  (rvalid),
    .i_mem_rdata   (rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program order restarts at the (word-aligned) target after reset or redirect.
  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_exp = {pc[31:2], 2'b00};
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    restart(pc);
    step();
    redirect = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect = 1'b0;
    restart(RPC);
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge i_clk);
      seen = mem_req && gnt;
    end
    check(name, 32'(seen), 32'd1);
    @(posedge i_clk);
    #2;
  endtask

  task automatic wait_acc_q(input string name, input logic [31:0] exp_addr);
    for (int i = 0; i < 40 && acc_q.size() == 0; i++) step();
    if (acc_q.size() == 0) check(name, 32'hDEAD_DEAD, exp_addr);
    else check(name, acc_q[0], exp_addr);
  endtask

  // Memory: one response per grant, 1+lat cycles later; no grant while a response is owed.
  initial begin : mem_model
    bit acc, pending;
    logic [31:0] a, paddr;
    int dly;
    pending = 0; paddr = '0; dly = 0;
    forever begin
      @(negedge i_clk);
      acc = mem_req && gnt;
      a   = mem_addr;
      if (acc) acc_q.push_back(a);
      @(posedge i_clk);
      #1;
      rvalid = 1'b0;
      if (acc) begin
        pending = 1;
        paddr   = a;
        dly     = $urandom_range(lat_max, lat_min);
      end
      if (pending) begin
        if (dly == 0) begin
          rvalid  = 1'b1;
          rdata   = mem_word(paddr);
          pending = 0;
        end else dly--;
      end
      gnt = !pending && ($urandom_range(99) < gnt_pct);
    end
  end

  initial begin : monitor
    fetch_entry_t e, f;
    bit hold;
    logic [31:0] haddr, model_stall;
    hold = 0; haddr = '0; model_stall = '0;
    forever begin
      @(negedge i_clk);
      if (rst) begin
        hold = 0;
        model_stall = '0;
        continue;
      end
      if (hold) begin
        check("req_held", 32'(mem_req), 32'd1);
        check("addr_held", mem_addr, haddr);
      end
      if (instr_valid && ready && !redirect) begin
        while (exp_q.size() < 4) begin
          f.pc = next_exp;
          f.instr = mem_word(next_exp);
          exp_q.push_back(f);
          next_exp += 32'd4;
        end
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", instr, e.instr);
        n_pop++;
      end
`ifdef IFU_PERF_CNT_EN
      check("stall_cnt", stall_cnt, model_stall);
      if (ready && !instr_valid && model_stall != 32'hFFFF_FFFF) model_stall++;
`endif
      hold  = mem_req && !gnt && !redirect;
      haddr = mem_addr;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a;
    bit found;
    restart(RPC);
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, RPC);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Basic streaming, 1-cycle memory, first-response latency
    acc_q.delete();
    ready = 1'b1;
    rst   = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rvalid) found = 1;
      else step();
    end
    check("first_rvalid", 32'(found), 32'd1);
    check("no_bypass", 32'(instr_valid), 32'd0);
    step();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_pc", instr_pc, RPC);
    check("first_instr", instr, mem_word(RPC));
    for (int i = 0; i < 30 && acc_q.size() < 3; i++) step();
    check("req_count_3", 32'(acc_q.size() >= 3), 32'd1);
    if (acc_q.size() >= 3) begin
      check("req0", acc_q[0], RPC);
      check("req1", acc_q[1], RPC + 32'd4);
      check("req2", acc_q[2], RPC + 32'd8);
    end

    // Credit limit with a stalled consumer
    ready = 1'b0;
    do_reset(2);
    acc_q.delete();
    repeat (20) step();
    check("credit_reqs", 32'(acc_q.size()), 32'd4);
    check("credit_req_low", 32'(mem_req), 32'd0);
    acc_q.delete();
    ready = 1'b1;
    step();
    ready = 1'b0;
    repeat (20) step();
    check("credit_one_more", 32'(acc_q.size()), 32'd1);
    check("credit_req_low2", 32'(mem_req), 32'd0);

    // Redirect while waiting for a response
    ready = 1'b1;
    lat_min = 2; lat_max = 2;
    repeat (6) step();
    wait_accept("wait_accept_redir");
    acc_q.delete();
    do_redirect(32'h0000_0103);
    wait_acc_q("redir_addr", 32'h0000_0100);
    for (int i = 0; i < 30 && !instr_valid; i++) step();
    check("redir_first_pc", instr_pc, 32'h0000_0100);

    // Redirect coinciding with rvalid and a pop
    lat_min = 0; lat_max = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rvalid && instr_valid) found = 1;
      else begin
        ready = ($urandom_range(3) == 0);
        step();
      end
    end
    check("rvalid_pop_found", 32'(found), 32'd1);
    ready = 1'b1;
    acc_q.delete();
    do_redirect(32'h0000_0200);
    check("flush_empty", 32'(instr_valid), 32'd0);
    wait_acc_q("redir2_addr", 32'h0000_0200);

    // Grant withheld: request and address must hold
    gnt_pct = 0;
    step();
    for (int i = 0; i < 20 && !mem_req; i++) step();
    a = mem_addr;
    repeat (5) begin
      step();
      check("gnt_low_req", 32'(mem_req), 32'd1);
      check("gnt_low_addr", mem_addr, a);
    end
    gnt_pct = 100;

    // Asynchronous reset while waiting; the stale response must be dropped
    lat_min = 4; lat_max = 4;
    repeat (4) step();
    wait_accept("wait_accept_rst");
    rst = 1'b1;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_mem_addr", mem_addr, RPC);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_instr_pc", instr_pc, 32'd0);
    restart(RPC);
    acc_q.delete();
    step(); step();
    rst = 1'b0;
    wait_acc_q("rst_restart_addr", RPC);

    // Random traffic
    lat_min = 0; lat_max = 3; gnt_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) begin
        if ($urandom_range(3) == 0) do_redirect(32'hFFFF_FFF9);
        else do_redirect($urandom & 32'h0000_0FFF);
      end else if ($urandom_range(399) == 0) do_reset(2);
      else step();
    end
    ready = 1'b1; gnt_pct = 100;
    repeat (20) step();
    check("pops_seen", 32'(n_pop > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
